// File: rtl/wb_uart_loader.sv
// Wishbone initiator driven by a UART byte stream: host frames select reads or writes,
// read data and a status byte are returned over the UART transmit byte interface.
module wb_uart_loader #(
    parameter logic [23:0] RX_TIMEOUT = 24'd5_000_000,
    parameter logic [15:0] WB_TIMEOUT = 16'd1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_busy,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic        o_hold,
    output logic        o_busy
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ST_ACK    = 8'h06;
    localparam logic [7:0] ST_NAK    = 8'h15;

    typedef enum logic [3:0] {
        IDLE, ADDR, CNT, DATA, WB_REQ, WB_WAIT, TX_BYTE, TX_GAP, STATUS
    } state_t;

    state_t state, state_next;

    logic [23:0] rx_shift;
    logic [1:0]  bidx;
    logic [29:0] word_addr;
    logic [15:0] cnt_rem;
    logic        is_write;
    logic        err;
    logic [31:0] rd_word;
    logic [23:0] rx_tmr;
    logic [15:0] wb_tmr;

    logic        rx_phase, rx_timeout, cmd_ok;
    logic        wb_active, wb_ack_seen, wb_abort, wb_start;
    logic        tx_fire;
    logic [31:0] rx_word;
    logic [15:0] cnt_new;
    state_t      after_ack;

    // Incoming bytes shift in from the top so multi-byte fields land little-endian.
    assign rx_word   = {i_rx_data, rx_shift};
    assign cnt_new   = {i_rx_data, rx_shift[23:16]};
    assign o_wb_addr = {word_addr, 2'b00};
    assign o_wb_sel  = 4'hF;
    assign o_busy    = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        rx_phase    = (state == ADDR) || (state == CNT) || (state == DATA);
        rx_timeout  = rx_phase && !i_rx_valid && (rx_tmr == RX_TIMEOUT - 24'd1);
        cmd_ok      = (state == IDLE) && i_rx_valid &&
                      ((i_rx_data == CMD_WRITE) || (i_rx_data == CMD_READ));
        wb_active   = (state == WB_REQ) || (state == WB_WAIT);
        wb_ack_seen = wb_active && i_wb_ack;
        wb_abort    = wb_active && !i_wb_ack && (wb_tmr == WB_TIMEOUT - 16'd1);
        tx_fire     = ((state == TX_BYTE) || (state == STATUS)) && !i_tx_busy;
        after_ack   = is_write ? ((cnt_rem == 16'd1) ? STATUS : DATA) : TX_BYTE;

        case (state)
            IDLE: begin
                if (cmd_ok) state_next = ADDR;
            end
            ADDR: begin
                if (rx_timeout)                         state_next = IDLE;
                else if (i_rx_valid && bidx == 2'd3)    state_next = CNT;
            end
            CNT: begin
                if (rx_timeout) begin
                    state_next = IDLE;
                end else if (i_rx_valid && bidx == 2'd1) begin
                    if (cnt_new == 16'd0)  state_next = STATUS;
                    else if (is_write)     state_next = DATA;
                    else                   state_next = WB_REQ;
                end
            end
            DATA: begin
                if (rx_timeout)                         state_next = IDLE;
                else if (i_rx_valid && bidx == 2'd3)    state_next = WB_REQ;
            end
            WB_REQ: begin
                if (wb_ack_seen)       state_next = after_ack;
                else if (wb_abort)     state_next = STATUS;
                else if (!i_wb_stall)  state_next = WB_WAIT;
            end
            WB_WAIT: begin
                if (wb_ack_seen)       state_next = after_ack;
                else if (wb_abort)     state_next = STATUS;
            end
            TX_BYTE: begin
                if (tx_fire) state_next = TX_GAP;
            end
            TX_GAP: begin
                // bidx wraps to zero once all four bytes of the word have gone out
                if (bidx != 2'd0)            state_next = TX_BYTE;
                else if (cnt_rem == 16'd0)   state_next = STATUS;
                else                         state_next = WB_REQ;
            end
            STATUS: begin
                if (tx_fire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        wb_start = (state_next == WB_REQ) && (state != WB_REQ);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_shift   <= '0;
            bidx       <= '0;
            word_addr  <= '0;
            cnt_rem    <= '0;
            is_write   <= 1'b0;
            err        <= 1'b0;
            rd_word    <= '0;
            rx_tmr     <= '0;
            wb_tmr     <= '0;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_data  <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            o_hold     <= 1'b0;
        end else begin
            o_tx_valid <= tx_fire;
            rx_tmr     <= (rx_phase && !i_rx_valid) ? rx_tmr + 24'd1 : 24'd0;

            if (state == IDLE) bidx <= 2'd0;

            if (cmd_ok) begin
                is_write <= (i_rx_data == CMD_WRITE);
                o_hold   <= (i_rx_data == CMD_WRITE);
                err      <= 1'b0;
            end

            if (rx_phase && i_rx_valid) begin
                rx_shift <= rx_word[31:8];
                bidx     <= (state == CNT && bidx == 2'd1) ? 2'd0 : bidx + 2'd1;
                if (state == ADDR && bidx == 2'd3) word_addr <= rx_word[31:2];
                if (state == CNT  && bidx == 2'd1) cnt_rem   <= cnt_new;
                if (state == DATA && bidx == 2'd3) o_wb_data <= rx_word;
            end

            if (rx_timeout) o_hold <= 1'b0;

            // Single pipelined transfer: stb drops once accepted, cyc holds until ack.
            if (wb_start) begin
                o_wb_cyc <= 1'b1;
                o_wb_stb <= 1'b1;
                o_wb_we  <= is_write;
                wb_tmr   <= 16'd0;
            end else if (wb_ack_seen) begin
                o_wb_cyc  <= 1'b0;
                o_wb_stb  <= 1'b0;
                o_wb_we   <= 1'b0;
                word_addr <= word_addr + 30'd1;
                cnt_rem   <= cnt_rem - 16'd1;
                if (!is_write) rd_word <= i_wb_data;
            end else if (wb_abort) begin
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
                o_wb_we  <= 1'b0;
                err      <= 1'b1;
            end else if (wb_active) begin
                wb_tmr <= wb_tmr + 16'd1;
                if (state == WB_REQ && !i_wb_stall) o_wb_stb <= 1'b0;
            end

            if (tx_fire) begin
                if (state == STATUS) begin
                    o_tx_data <= err ? ST_NAK : ST_ACK;
                    o_hold    <= 1'b0;
                end else begin
                    o_tx_data <= rd_word[7:0];
                    rd_word   <= {8'h00, rd_word[31:8]};
                    bidx      <= bidx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_uart_loader.sv
// Directed bench for wb_uart_loader: UART host frames in, Wishbone slave and UART TX models out.
`timescale 1ns/1ps
module tb_wb_uart_loader;

    localparam logic [23:0] RXT = 24'd200;
    localparam logic [15:0] WBT = 16'd16;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy = 1'b0;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_stall = 1'b0;
    logic        wb_ack = 1'b0;
    logic [31:0] wb_rdata = 32'h0;
    logic        hold, busy;

    int vectors = 0;
    int miscompares = 0;

    // Slave model configuration and logs
    int          slv_stall = 0;
    int          slv_ack_dly = 1;
    bit          slv_noack = 1'b0;
    logic [31:0] slv_data = 32'h0;
    bit          stb_new = 1'b1;
    bit          pending = 1'b0;
    int          stall_left = 0;
    int          ack_cnt = 0;
    logic [31:0] x_addr [32];
    logic [31:0] x_data [32];
    logic        x_we   [32];
    logic [3:0]  x_sel  [32];
    logic        x_hold [32];
    int          n_xfer = 0;
    int          stb_cyc = 0;
    int          cyc_cyc = 0;
    int          hold_cyc = 0;

    logic [7:0]  t_byte [64];
    logic        t_hold [64];
    int          n_tx = 0;
    int          busy_cnt = 0;

    wb_uart_loader #(.RX_TIMEOUT(RXT), .WB_TIMEOUT(WBT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_busy(tx_busy),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata),
        .o_hold(hold), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wishbone slave: optional stall on the first strobe cycles, ack a fixed delay after acceptance.
    always @(negedge clk) begin
        wb_ack   = 1'b0;
        wb_stall = 1'b0;
        wb_rdata = 32'h0;
        if (wb_cyc) cyc_cyc++;
        if (wb_stb) stb_cyc++;
        if (hold)   hold_cyc++;
        if (!wb_cyc) begin
            stb_new = 1'b1;
            pending = 1'b0;
        end else if (wb_stb) begin
            if (stb_new) begin
                stb_new    = 1'b0;
                stall_left = slv_stall;
            end
            if (stall_left > 0) begin
                stall_left--;
                wb_stall = 1'b1;
            end else begin
                if (n_xfer < 32) begin
                    x_addr[n_xfer] = wb_addr;
                    x_data[n_xfer] = wb_wdata;
                    x_we[n_xfer]   = wb_we;
                    x_sel[n_xfer]  = wb_sel;
                    x_hold[n_xfer] = hold;
                end
                n_xfer++;
                ack_cnt = slv_ack_dly;
                pending = 1'b1;
                if (ack_cnt == 0 && !slv_noack) begin
                    wb_ack   = 1'b1;
                    wb_rdata = slv_data;
                    pending  = 1'b0;
                end
            end
        end else if (pending) begin
            if (ack_cnt > 0) ack_cnt--;
            if (ack_cnt == 0 && !slv_noack) begin
                wb_ack   = 1'b1;
                wb_rdata = slv_data;
                pending  = 1'b0;
            end
        end
    end

    // UART transmitter: goes busy for a few cycles after each accepted byte.
    always @(negedge clk) begin
        if (tx_valid) begin
            if (n_tx < 64) begin
                t_byte[n_tx] = tx_data;
                t_hold[n_tx] = hold;
            end
            n_tx++;
            busy_cnt = 3;
            tx_busy  = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a, input logic [15:0] c);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
    endtask

    task automatic wait_idle(input int bound, input string name);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s: o_busy still 1 after %0d cycles, want 0", name, bound);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk); #1;
        vectors++; if (wb_cyc !== 1'b0) begin miscompares++; $display("FAIL rst_cyc: got %b want 0", wb_cyc); end
        vectors++; if (wb_stb !== 1'b0) begin miscompares++; $display("FAIL rst_stb: got %b want 0", wb_stb); end
        vectors++; if (wb_we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", wb_we); end
        vectors++; if (wb_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", wb_addr); end
        vectors++; if (wb_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_wdata: got %h want 0", wb_wdata); end
        vectors++; if (wb_sel !== 4'hF) begin miscompares++; $display("FAIL rst_sel: got %h want F", wb_sel); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_txv: got %b want 0", tx_valid); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_txd: got %h want 00", tx_data); end
        vectors++; if (hold !== 1'b0) begin miscompares++; $display("FAIL rst_hold: got %b want 0", hold); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_write_two;
        int x0 = n_xfer;
        int t0 = n_tx;
        slv_stall = 0; slv_ack_dly = 1; slv_noack = 1'b0;
        send_byte(8'h57);
        vectors++; if (hold !== 1'b1) begin miscompares++; $display("FAIL wr_hold_cmd: got %b want 1", hold); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy_cmd: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) send_byte((i == 1) ? 8'h01 : 8'h00);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h12345678);
        vectors++; if (hold !== 1'b1) begin miscompares++; $display("FAIL wr_hold_mid: got %b want 1", hold); end
        send_word(32'hDEADBEEF);
        wait_idle(200, "wr_done");
        vectors++; if (n_xfer - x0 !== 2) begin miscompares++; $display("FAIL wr_nxfer: got %0d want 2", n_xfer - x0); end
        vectors++; if (x_addr[x0] !== 32'h100) begin miscompares++; $display("FAIL wr_addr0: got %h want 00000100", x_addr[x0]); end
        vectors++; if (x_data[x0] !== 32'h12345678) begin miscompares++; $display("FAIL wr_data0: got %h want 12345678", x_data[x0]); end
        vectors++; if (x_we[x0] !== 1'b1) begin miscompares++; $display("FAIL wr_we0: got %b want 1", x_we[x0]); end
        vectors++; if (x_sel[x0] !== 4'hF) begin miscompares++; $display("FAIL wr_sel0: got %h want F", x_sel[x0]); end
        vectors++; if (x_hold[x0] !== 1'b1) begin miscompares++; $display("FAIL wr_hold0: got %b want 1", x_hold[x0]); end
        vectors++; if (x_addr[x0+1] !== 32'h104) begin miscompares++; $display("FAIL wr_addr1: got %h want 00000104", x_addr[x0+1]); end
        vectors++; if (x_data[x0+1] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_data1: got %h want deadbeef", x_data[x0+1]); end
        vectors++; if (x_hold[x0+1] !== 1'b1) begin miscompares++; $display("FAIL wr_hold1: got %b want 1", x_hold[x0+1]); end
        vectors++; if (n_tx - t0 !== 1) begin miscompares++; $display("FAIL wr_ntx: got %0d want 1", n_tx - t0); end
        vectors++; if (t_byte[t0] !== 8'h06) begin miscompares++; $display("FAIL wr_status: got %h want 06", t_byte[t0]); end
        vectors++; if (t_hold[t0] !== 1'b0) begin miscompares++; $display("FAIL wr_hold_at_status: got %b want 0", t_hold[t0]); end
        vectors++; if (hold !== 1'b0) begin miscompares++; $display("FAIL wr_hold_end: got %b want 0", hold); end
        vectors++; if (wb_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_wdata_held: got %h want deadbeef", wb_wdata); end
    endtask

    task automatic test_read_stall;
        int x0 = n_xfer;
        int t0 = n_tx;
        int s0 = stb_cyc;
        int c0 = cyc_cyc;
        int h0 = hold_cyc;
        logic [7:0] exp [5];
        exp[0] = 8'hBE; exp[1] = 8'hBA; exp[2] = 8'hFE; exp[3] = 8'hCA; exp[4] = 8'h06;
        slv_stall = 3; slv_ack_dly = 2; slv_data = 32'hCAFEBABE;
        send_hdr(8'h52, 32'h0000_0103, 16'd1);
        wait_idle(300, "rd_done");
        slv_stall = 0;
        vectors++; if (n_xfer - x0 !== 1) begin miscompares++; $display("FAIL rd_nxfer: got %0d want 1", n_xfer - x0); end
        vectors++; if (x_addr[x0] !== 32'h100) begin miscompares++; $display("FAIL rd_addr: got %h want 00000100", x_addr[x0]); end
        vectors++; if (x_we[x0] !== 1'b0) begin miscompares++; $display("FAIL rd_we: got %b want 0", x_we[x0]); end
        vectors++; if (stb_cyc - s0 !== 4) begin miscompares++; $display("FAIL rd_stb_cycles: got %0d want 4", stb_cyc - s0); end
        vectors++; if (cyc_cyc - c0 !== 6) begin miscompares++; $display("FAIL rd_cyc_cycles: got %0d want 6", cyc_cyc - c0); end
        vectors++; if (hold_cyc - h0 !== 0) begin miscompares++; $display("FAIL rd_hold_cycles: got %0d want 0", hold_cyc - h0); end
        vectors++; if (n_tx - t0 !== 5) begin miscompares++; $display("FAIL rd_ntx: got %0d want 5", n_tx - t0); end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (t_byte[t0+i] !== exp[i]) begin
                miscompares++;
                $display("FAIL rd_tx%0d: got %h want %h", i, t_byte[t0+i], exp[i]);
            end
        end
    endtask

    task automatic test_addr_wrap;
        int x0 = n_xfer;
        int t0 = n_tx;
        slv_ack_dly = 1;
        send_hdr(8'h57, 32'hFFFF_FFFC, 16'd2);
        send_word(32'h11223344);
        send_word(32'h55667788);
        wait_idle(200, "wrap_done");
        vectors++; if (n_xfer - x0 !== 2) begin miscompares++; $display("FAIL wrap_nxfer: got %0d want 2", n_xfer - x0); end
        vectors++; if (x_addr[x0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0: got %h want fffffffc", x_addr[x0]); end
        vectors++; if (x_addr[x0+1] !== 32'h0) begin miscompares++; $display("FAIL wrap_addr1: got %h want 00000000", x_addr[x0+1]); end
        vectors++; if (x_data[x0+1] !== 32'h55667788) begin miscompares++; $display("FAIL wrap_data1: got %h want 55667788", x_data[x0+1]); end
        vectors++; if (t_byte[t0] !== 8'h06) begin miscompares++; $display("FAIL wrap_status: got %h want 06", t_byte[t0]); end
    endtask

    task automatic test_wb_timeout;
        int x0 = n_xfer;
        int t0 = n_tx;
        int c0 = cyc_cyc;
        slv_noack = 1'b1;
        send_hdr(8'h52, 32'h0000_0200, 16'd3);
        wait_idle(300, "to_done");
        slv_noack = 1'b0;
        vectors++; if (n_xfer - x0 !== 1) begin miscompares++; $display("FAIL to_nxfer: got %0d want 1", n_xfer - x0); end
        vectors++; if (cyc_cyc - c0 !== int'(WBT)) begin miscompares++; $display("FAIL to_cyc_cycles: got %0d want %0d", cyc_cyc - c0, WBT); end
        vectors++; if (n_tx - t0 !== 1) begin miscompares++; $display("FAIL to_ntx: got %0d want 1", n_tx - t0); end
        vectors++; if (t_byte[t0] !== 8'h15) begin miscompares++; $display("FAIL to_status: got %h want 15", t_byte[t0]); end
    endtask

    task automatic test_rx_timeout;
        int x0;
        int t0 = n_tx;
        logic [7:0] exp [5];
        exp[0] = 8'h0D; exp[1] = 8'hF0; exp[2] = 8'hAD; exp[3] = 8'h0B; exp[4] = 8'h06;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h01);
        repeat (int'(RXT) - 10) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rxto_busy_before: got %b want 1", busy); end
        vectors++; if (hold !== 1'b1) begin miscompares++; $display("FAIL rxto_hold_before: got %b want 1", hold); end
        repeat (15) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rxto_busy_after: got %b want 0", busy); end
        vectors++; if (hold !== 1'b0) begin miscompares++; $display("FAIL rxto_hold_after: got %b want 0", hold); end
        vectors++; if (n_tx - t0 !== 0) begin miscompares++; $display("FAIL rxto_ntx: got %0d want 0", n_tx - t0); end
        x0 = n_xfer;
        t0 = n_tx;
        slv_ack_dly = 0; slv_data = 32'h0BADF00D;
        send_hdr(8'h52, 32'h0000_0040, 16'd1);
        wait_idle(300, "rxto_read_done");
        slv_ack_dly = 1;
        vectors++; if (x_addr[x0] !== 32'h40) begin miscompares++; $display("FAIL rxto_rd_addr: got %h want 00000040", x_addr[x0]); end
        vectors++; if (n_tx - t0 !== 5) begin miscompares++; $display("FAIL rxto_rd_ntx: got %0d want 5", n_tx - t0); end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (t_byte[t0+i] !== exp[i]) begin
                miscompares++;
                $display("FAIL rxto_rd_tx%0d: got %h want %h", i, t_byte[t0+i], exp[i]);
            end
        end
    endtask

    task automatic test_garbage_cnt0;
        int x0 = n_xfer;
        int t0 = n_tx;
        int c0 = cyc_cyc;
        send_byte(8'h41);
        repeat (3) @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL garbage_busy: got %b want 0", busy); end
        vectors++; if (hold !== 1'b0) begin miscompares++; $display("FAIL garbage_hold: got %b want 0", hold); end
        send_hdr(8'h57, 32'h0000_0200, 16'd0);
        wait_idle(100, "cnt0_done");
        vectors++; if (n_tx - t0 !== 1) begin miscompares++; $display("FAIL cnt0_ntx: got %0d want 1", n_tx - t0); end
        vectors++; if (t_byte[t0] !== 8'h06) begin miscompares++; $display("FAIL cnt0_status: got %h want 06", t_byte[t0]); end
        vectors++; if (n_xfer - x0 !== 0) begin miscompares++; $display("FAIL cnt0_nxfer: got %0d want 0", n_xfer - x0); end
        vectors++; if (cyc_cyc - c0 !== 0) begin miscompares++; $display("FAIL cnt0_cyc: got %0d want 0", cyc_cyc - c0); end
        vectors++; if (hold !== 1'b0) begin miscompares++; $display("FAIL cnt0_hold: got %b want 0", hold); end
    endtask

    task automatic test_reset_midxfer;
        int t0 = n_tx;
        slv_noack = 1'b1;
        send_hdr(8'h57, 32'h0000_0300, 16'd1);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        repeat (3) @(posedge clk); #1;
        vectors++; if (wb_cyc !== 1'b1) begin miscompares++; $display("FAIL rstx_cyc_before: got %b want 1", wb_cyc); end
        vectors++; if (hold !== 1'b1) begin miscompares++; $display("FAIL rstx_hold_before: got %b want 1", hold); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (wb_cyc !== 1'b0) begin miscompares++; $display("FAIL rstx_cyc: got %b want 0", wb_cyc); end
        vectors++; if (wb_stb !== 1'b0) begin miscompares++; $display("FAIL rstx_stb: got %b want 0", wb_stb); end
        vectors++; if (hold !== 1'b0) begin miscompares++; $display("FAIL rstx_hold: got %b want 0", hold); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstx_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        slv_noack = 1'b0;
        repeat (40) @(posedge clk); #1;
        vectors++; if (n_tx - t0 !== 0) begin miscompares++; $display("FAIL rstx_ntx: got %0d want 0", n_tx - t0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstx_idle: got %b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        test_reset();
        test_write_two();
        test_read_stall();
        test_addr_wrap();
        test_wb_timeout();
        test_rx_timeout();
        test_garbage_cnt0();
        test_reset_midxfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_uart_loader.md
Name: wb_uart_loader

Overview:
- Wishbone initiator driven by the UART byte stream: receives host commands as bytes from the UART bridge and issues Wishbone reads/writes into the slave arbiter.
- Read results and a status byte go back over the UART TX byte interface.
- Used to load programs into BRAM/SDRAM and to inspect memory. Holds the CPU in reset during write sessions via o_hold.

Parameters:
- RX_TIMEOUT, 24'd5_000_000: idle cycles between RX bytes of one command before the partial command is discarded.
- WB_TIMEOUT, 16'd1024: cycles allowed from stb issue to ack before the transfer is aborted.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- o_tx_data  out  8  byte to transmit
- o_tx_valid  out  1  one-cycle strobe requesting transmission of o_tx_data
- i_tx_busy  in  1  transmitter busy
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- o_wb_we  out  1  write enable
- o_wb_addr  out  32  byte address, bits [1:0] always 0
- o_wb_data  out  32  write data
- o_wb_sel  out  4  byte select, always 4'hF
- i_wb_stall  in  1  slave stall
- i_wb_ack  in  1  slave acknowledge
- i_wb_data  in  32  read data
- o_hold  out  1  high from write-command byte until its status byte is queued
- o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, i_rst=1):
  - State goes to IDLE.
  - All outputs are 0, except o_wb_sel=4'hF.
  - All counters and timers are 0.
  - Reset mid-transfer drops o_wb_cyc/o_wb_stb immediately. No status byte is sent.
- Frame format (all multi-byte fields little-endian):
  - CMD: 0x57 = write, 0x52 = read.
  - ADDR: 4 bytes. Bits [1:0] are forced to 0.
  - CNT: 2 bytes, word count.
  - Write only: CNT×4 data bytes.
- In IDLE, any byte other than 0x57/0x52 is ignored and no response is sent.
- States: IDLE -> ADDR(4 bytes) -> CNT(2 bytes) -> then one of:
  - write: DATA -> WB_REQ -> WB_WAIT -> DATA ... -> STATUS
  - read: WB_REQ -> WB_WAIT -> TX_BYTE ×4 ... -> STATUS
- RX timeout:
  - Applies in ADDR, CNT and DATA.
  - The timer resets on each i_rx_valid.
  - Reaching RX_TIMEOUT returns to IDLE with no response and o_hold cleared.
- Bytes arriving in WB_REQ, WB_WAIT, TX_* or STATUS are dropped. The host must pace its writes.
- Wishbone pipelined single transfer:
  - WB_REQ asserts cyc=1 and stb=1.
  - stb stays high until sampled with i_wb_stall=0, then drops the next cycle.
  - cyc stays high until i_wb_ack. cyc and stb both drop the cycle after ack.
  - For reads, i_wb_data is captured on ack.
  - Ack arriving in the same cycle as the accepted stb is legal.
- After each transfer, address += 4 (wraps mod 2^32) and remaining count -= 1.
- WB timeout:
  - Counter runs from stb assertion to ack.
  - Reaching WB_TIMEOUT drops cyc/stb, sets the error flag, skips any remaining transfers and goes to STATUS.
- TX handshake:
  - o_tx_valid pulses for 1 cycle only when i_tx_busy=0.
  - Then wait 1 cycle, then wait for i_tx_busy=0 before the next byte.
  - Read words are sent LSB first.
- STATUS sends 0x06 on success or 0x15 if the error flag is set, then returns to IDLE.
- o_hold clears in the cycle the status byte's o_tx_valid pulses.
- CNT=0: no Wishbone activity; the status byte 0x06 is sent directly.
- o_wb_data holds the assembled word from the last DATA byte until the next word completes.

Test Plan:
- Write 2 words: bytes 57, 00 01 00 00, 02 00, 78 56 34 12, EF BE AD DE -> two WB writes, adr 0x100 dat 0x12345678 then adr 0x104 dat 0xDEADBEEF, sel F; TX 0x06; o_hold high throughout, low after status.
- Read 1 word from 0x103 with slave returning 0xCAFEBABE, stall=1 for 3 cycles, ack 2 cycles later -> o_wb_addr=0x100, stb held through stall; TX 0xBE, 0xBA, 0xFE, 0xCA, 0x06; o_hold stays 0.
- Address wrap: write 2 words at 0xFFFFFFFC -> adr 0xFFFFFFFC then 0x00000000; TX 0x06.
- Slave never acks, read CNT=3 -> cyc drops after WB_TIMEOUT cycles, only one WB attempt; TX 0x15 with no data bytes.
- Partial frame: 57 00 01 then silence for RX_TIMEOUT cycles -> IDLE, no TX, o_hold=0; a following valid read command executes normally.
- Garbage 0x41 in IDLE -> ignored. CNT=0 write -> TX 0x06, no cyc. Assert i_rst during WB_WAIT -> cyc/stb/o_hold go 0 at once, no TX.
